// File: rtl/seq_pattern_checker.sv
// seq_pattern_checker: locks onto a parameterised 4-bit value sequence and
// flags/counts deviations once locked.
// Ports: clk, reset (async, active-high), in_valid, seq_in[3:0], err_clr ->
//   locked, mismatch (1-cycle pulse), expected[3:0], err_count[ERR_W-1:0].
// Optional: define SEQ_PATTERN_CHECKER_RESYNC_EN to re-hunt on the error sample.
module seq_pattern_checker #(
  parameter int          SEQ_LEN     = 8,
  parameter logic [63:0] SEQ_TABLE   = 64'h0000_0000_8CEF_7310,
  parameter int          LOCK_THRESH = 4,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       seq_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             mismatch,
  output logic [3:0]       expected,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  localparam logic [7:0] THR = 8'(LOCK_THRESH);

  state_t     state, state_n, hunt_state;
  logic [3:0] idx, idx_n, hunt_idx;
  logic [7:0] run, run_n, hunt_run;
  logic       mis_n;
  logic       hit, hit0;

  function automatic logic [3:0] entry(input logic [3:0] i);
    return SEQ_TABLE[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inc(input logic [3:0] i);
    return (i == 4'(SEQ_LEN - 1)) ? 4'd0 : i + 4'd1;
  endfunction

  assign hit  = (seq_in == entry(idx));
  assign hit0 = (seq_in == entry(4'd0));

  // Outcome of treating the current sample as a fresh HUNT candidate.
  always_comb begin
    hunt_state = HUNT;
    hunt_idx   = 4'd0;
    hunt_run   = 8'd0;
    if (hit0) begin
      hunt_state = (THR == 8'd1) ? LOCKED : TRACK;
      hunt_idx   = inc(4'd0);
      hunt_run   = 8'd1;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    run_n   = run;
    mis_n   = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          state_n = hunt_state;
          idx_n   = hunt_idx;
          run_n   = hunt_run;
        end
        TRACK: begin
          if (hit) begin
            idx_n = inc(idx);
            if (run + 8'd1 >= THR) begin
              state_n = LOCKED;
              run_n   = THR;
            end else begin
              run_n = run + 8'd1;
            end
          end else begin
            state_n = hunt_state;
            idx_n   = hunt_idx;
            run_n   = hunt_run;
          end
        end
        LOCKED: begin
          if (hit) begin
            idx_n = inc(idx);
          end else begin
            mis_n = 1'b1;
`ifdef SEQ_PATTERN_CHECKER_RESYNC_EN
            state_n = hunt_state;
            idx_n   = hunt_idx;
            run_n   = hunt_run;
`else
            state_n = HUNT;
            idx_n   = 4'd0;
            run_n   = 8'd0;
`endif
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = 4'd0;
          run_n   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      idx       <= 4'd0;
      run       <= 8'd0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      expected  <= entry(4'd0);
      err_count <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      run      <= run_n;
      locked   <= (state_n == LOCKED);
      mismatch <= mis_n;
      // HUNT always carries idx 0, so this yields entry0 there.
      expected <= entry(idx_n);
      // A same-edge mismatch overrides the clear: result is 1.
      if (mis_n) begin
        if (err_clr)
          err_count <= ERR_W'(1);
        else if (!(&err_count))
          err_count <= err_count + ERR_W'(1);
      end else if (err_clr) begin
        err_count <= '0;
      end
    end
  end

endmodule
